data_memory_lanes: RTL and testbench
====================================

Name: data_memory_lanes

Overview:
Next-generation data memory for the MIPS datapath, placed behind the ALU address output.
- Adds byte, halfword and word access with sign or zero extension (sb/sh/sw, lb/lbu/lh/lhu/lw).
- Adds a configurable synchronous read latency with a valid/busy handshake, so the memory can later map onto block RAM.
- Detects misaligned and out-of-range accesses instead of silently aliasing.

Parameters:
MEMORY_DEPTH, 256, number of 32-bit words.
BASE_ADDR, 32'h1001_0000, byte address of word 0.
READ_LATENCY, 1, clock edges from read accept to valid_o; legal range 1..4.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
address_i  input  32  byte address.
write_data_i  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
mem_write_i  input  1  write request.
mem_read_i  input  1  read request.
size_i  input  2  00 byte, 01 half, 10 word; 11 is illegal.
unsigned_i  input  1  1 = zero-extend loads, 0 = sign-extend; ignored for word.
data_o  output  32  load result, extended to 32 bits.
valid_o  output  1  one-cycle pulse: data_o/error_o carry a read response.
busy_o  output  1  read in flight; requests ignored.
error_o  output  1  one-cycle error pulse.

Behaviour:
- Word index = (address_i - BASE_ADDR) >> 2. Byte offset = address_i[1:0]. Little-endian: lane k is bits [8k+7:8k].
- Error conditions for a request:
  - address_i < BASE_ADDR;
  - index >= MEMORY_DEPTH;
  - size_i = 11;
  - half access with address_i[0] = 1;
  - word access with address_i[1:0] != 0;
  - mem_read_i and mem_write_i both high.
- FSM states: IDLE, WAIT, RESP.
  - A request is accepted at a rising edge only in IDLE or RESP, i.e. only when busy_o = 0.
  - busy_o = (state == WAIT).
- Write, accepted at edge E:
  - Legal: at E, only the addressed lanes are updated. Byte updates lane offset. Half updates lanes offset and offset+1. Word updates all lanes. Other lanes keep their value.
  - FSM goes to IDLE, or stays in IDLE.
  - Illegal: memory is unchanged and error_o is high for the cycle after E.
  - valid_o is never asserted for a write.
- Read, accepted at edge E:
  - At E, latch index, offset, size and unsigned; counter = READ_LATENCY - 1; FSM goes to WAIT.
  - WAIT: the counter decrements each edge. At the edge where it is 0, the RAM word is sampled, extraction and extension are performed, data_o is registered, and the FSM goes to RESP.
  - RESP: valid_o = 1 for exactly that one cycle (edge E+READ_LATENCY to E+READ_LATENCY+1). A new request is accepted at the edge that ends RESP (back-to-back reads). With no request, the FSM returns to IDLE.
  - Extraction:
    - byte: lane at offset, bit 7 replicated (signed) or zero-filled;
    - half: lanes at offset, bit 15 replicated or zero-filled;
    - word: unchanged.
  - Illegal read: still takes READ_LATENCY. The response cycle has valid_o = 1, error_o = 1 and data_o = 0; no RAM word is read.
- data_o holds the last response value until the next response.
- Requests presented while busy_o = 1 are ignored (no write, no queueing). The requester must hold the request until busy_o = 0.
- Reset (asynchronous, any state, including mid-read):
  - FSM goes to IDLE and the counter to 0;
  - data_o = 0, valid_o = 0, busy_o = 0, error_o = 0;
  - an in-flight read is discarded and produces no response;
  - memory contents are not reset.

Test Plan:
- Word write/read, READ_LATENCY=1: sw 32'hDEADBEEF at 0x1001_0004, then lw 0x1001_0004 -> valid_o exactly 1 edge after accept with data_o=32'hDEADBEEF, busy_o high for 1 cycle, error_o=0.
- Byte lanes and extension: sw 0 at 0x1001_0008; sb 8'h80 at 0x1001_000A -> word reads 32'h0080_0000. lb 0x1001_000A -> 32'hFFFF_FF80. lbu -> 32'h0000_0080. sh 16'h8001 at 0x1001_0008; lh 0x1001_0008 -> 32'hFFFF_8001.
- Errors: sh at 0x1001_0001 -> error_o pulse, word unchanged. lw at 0x1001_0400 (index 256) -> valid_o=1, error_o=1, data_o=0. lw at 0x1000_FFFC -> same response. Simultaneous read and write -> error pulse, no write.
- Latency/handshake, READ_LATENCY=3: lw accepted at edge E -> busy_o high for 3 cycles, valid_o at E+3. A sw presented during busy is ignored (target word unchanged). A back-to-back lw presented in the RESP cycle is accepted and answered at E+7.
- Reset mid-read, READ_LATENCY=4: assert reset 2 cycles after accept -> outputs 0 immediately, no valid_o afterwards. Memory retains previously written 32'h1234_5678.

Source files
------------

// File: rtl/data_memory_lanes.sv
// Byte/half/word data memory for the MIPS datapath with sign/zero-extended loads,
// a programmable read latency and misaligned/out-of-range access detection.
module data_memory_lanes #(
    parameter int unsigned MEMORY_DEPTH = 256,
    parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address_i,
    input  logic [31:0] write_data_i,
    input  logic        mem_write_i,
    input  logic        mem_read_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o,
    output logic        valid_o,
    output logic        busy_o,
    output logic        error_o
);
    localparam int unsigned AW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [1:0]    off_q, off_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic          rerr_q, rerr_d;
    logic [31:0]   data_q, data_d;
    logic          error_q, error_d;

    logic [31:0]   mem_q [MEMORY_DEPTH];

    logic [31:0]   rel_addr;
    logic          req_err;
    logic          accept;
    logic          rd_go;
    logic          mem_we;
    logic          resp_edge;
    logic [3:0]    lane_en;
    logic [31:0]   lane_data;

    // Handshake: a request is taken on a rising edge only while busy_o is low;
    // the requester holds it until then. valid_o marks the single response cycle.
    assign rel_addr  = address_i - BASE_ADDR;
    assign accept    = (state_q != ST_WAIT);
    assign rd_go     = accept && mem_read_i && !mem_write_i;
    assign mem_we    = accept && mem_write_i && !mem_read_i && !req_err;
    assign resp_edge = (state_q == ST_WAIT) && (cnt_q == 2'd0);

    always_comb begin
        req_err = 1'b0;
        if (address_i < BASE_ADDR)                           req_err = 1'b1;
        if (rel_addr[31:2] >= 30'(MEMORY_DEPTH))             req_err = 1'b1;
        if (size_i == 2'b11)                                 req_err = 1'b1;
        if (size_i == 2'b01 && address_i[0])                 req_err = 1'b1;
        if (size_i == 2'b10 && address_i[1:0] != 2'b00)      req_err = 1'b1;
        if (mem_read_i && mem_write_i)                       req_err = 1'b1;
    end

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] off,
                                            input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = {{24{b[7] & ~uns}}, b};
            2'b01:   r = {{16{h[15] & ~uns}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (rd_go) begin
                    state_d = ST_WAIT;
                    cnt_d   = 2'(READ_LATENCY - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 2'd0) state_d = ST_RESP;
                else               cnt_d   = cnt_q - 2'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy_o  = (state_q == ST_WAIT);
        valid_o = (state_q == ST_RESP);
    end

    always_comb begin
        idx_d   = idx_q;
        off_d   = off_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rerr_d  = rerr_q;
        data_d  = data_q;
        // Write errors (including read+write together) pulse on the cycle after accept.
        error_d = accept && mem_write_i && req_err;
        if (rd_go) begin
            idx_d  = rel_addr[AW+1:2];
            off_d  = rel_addr[1:0];
            size_d = size_i;
            uns_d  = unsigned_i;
            rerr_d = req_err;
        end
        if (resp_edge) begin
            data_d  = rerr_q ? 32'h0 : extract(mem_q[idx_q], off_q, size_q, uns_q);
            error_d = rerr_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q   <= '0;
            off_q   <= 2'd0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            rerr_q  <= 1'b0;
            data_q  <= 32'h0;
            error_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            off_q   <= off_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rerr_q  <= rerr_d;
            data_q  <= data_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        case (size_i)
            2'b00: begin
                lane_en   = 4'b0001 << rel_addr[1:0];
                lane_data = {4{write_data_i[7:0]}};
            end
            2'b01: begin
                lane_en   = 4'b0011 << rel_addr[1:0];
                lane_data = {2{write_data_i[15:0]}};
            end
            default: begin
                lane_en   = 4'b1111;
                lane_data = write_data_i;
            end
        endcase
    end

    // Storage is deliberately not reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_en[k]) mem_q[rel_addr[AW+1:2]][8*k +: 8] <= lane_data[8*k +: 8];
            end
        end
    end

    assign data_o  = data_q;
    assign error_o = error_q;

endmodule

// File: tb/tb_data_memory_lanes.sv
// Bench for data_memory_lanes: three instances (read latency 1, 3, 4) driven by
// directed vectors, with responses checked against an expected-response queue.
module tb_data_memory_lanes;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [3];
    logic [31:0] addr [3];
    logic [31:0] wdat [3];
    logic        mrd  [3];
    logic        mwr  [3];
    logic [1:0]  sz   [3];
    logic        uns  [3];
    logic [31:0] dout [3];
    logic        vld  [3];
    logic        bsy  [3];
    logic        err  [3];

    int checks = 0;
    int errors = 0;
    // {dut id[1:0], valid, error, data[31:0]}
    logic [35:0] exp_q[$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_memory_lanes #(
            .MEMORY_DEPTH(256),
            .BASE_ADDR(32'h1001_0000),
            .READ_LATENCY((g == 0) ? 1 : (g == 1) ? 3 : 4)
        ) u_dut (
            .clk(clk),
            .reset(rst[g]),
            .address_i(addr[g]),
            .write_data_i(wdat[g]),
            .mem_write_i(mwr[g]),
            .mem_read_i(mrd[g]),
            .size_i(sz[g]),
            .unsigned_i(uns[g]),
            .data_o(dout[g]),
            .valid_o(vld[g]),
            .busy_o(bsy[g]),
            .error_o(err[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [35:0] e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (vld[d] === 1'b1 || err[d] === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_pulse dut=%0d valid=%b error=%b data=%h required=no_pulse",
                                 d, vld[d], err[d], dout[d]);
                    end else begin
                        e = exp_q.pop_front();
                        if (e[35:34] != 2'(d) || vld[d] !== e[33] || err[d] !== e[32] ||
                            (e[33] && dout[d] !== e[31:0])) begin
                            errors++;
                            $display("FAIL response dut=%0d valid=%b error=%b data=%h required dut=%0d valid=%b error=%b data=%h",
                                     d, vld[d], err[d], dout[d], e[35:34], e[33], e[32], e[31:0]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic issue(input int d, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] s, input logic u);
        int n;
        addr[d] = a; wdat[d] = wd; mrd[d] = rd; mwr[d] = wr; sz[d] = s; uns[d] = u;
        n = 0;
        while (bsy[d] === 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("issue_wait_cycles_ok", 32'(n < 20), 32'd1);
        @(posedge clk); #1;
        mrd[d] = 1'b0;
        mwr[d] = 1'b0;
    endtask

    task automatic wait_resp(input int d, input int lat, input string name);
        for (int i = 0; i < lat; i++) begin
            chk({name, "_busy"}, 32'(bsy[d]), 32'd1);
            chk({name, "_valid_low"}, 32'(vld[d]), 32'd0);
            @(posedge clk); #1;
        end
        chk({name, "_valid"}, 32'(vld[d]), 32'd1);
        chk({name, "_busy_low"}, 32'(bsy[d]), 32'd0);
    endtask

    task automatic store(input int d, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] s, input logic exp_err);
        if (exp_err) exp_q.push_back({2'(d), 1'b0, 1'b1, 32'h0});
        issue(d, 1'b0, 1'b1, a, wd, s, 1'b0);
    endtask

    task automatic load(input int d, input int lat, input logic [31:0] a, input logic [1:0] s,
                        input logic u, input logic exp_err, input logic [31:0] exp_data,
                        input string name);
        exp_q.push_back({2'(d), 1'b1, exp_err, exp_err ? 32'h0 : exp_data});
        issue(d, 1'b1, 1'b0, a, 32'h0, s, u);
        wait_resp(d, lat, name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_valid;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; addr[d] = 32'h0; wdat[d] = 32'h0; mrd[d] = 1'b0;
            mwr[d] = 1'b0; sz[d] = 2'b10; uns[d] = 1'b0;
        end
        fork
            monitor();
        join_none
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            chk("reset_data", dout[d], 32'h0);
            chk("reset_valid", 32'(vld[d]), 32'd0);
            chk("reset_busy", 32'(bsy[d]), 32'd0);
            chk("reset_error", 32'(err[d]), 32'd0);
        end

        // Latency 1: word access, byte/half lanes and extension
        store(0, 32'h1001_0004, 32'hDEAD_BEEF, 2'b10, 1'b0);
        load(0, 1, 32'h1001_0004, 2'b10, 1'b0, 1'b0, 32'hDEAD_BEEF, "lw_deadbeef");
        store(0, 32'h1001_0008, 32'h0, 2'b10, 1'b0);
        store(0, 32'h1001_000A, 32'h1234_5680, 2'b00, 1'b0);
        load(0, 1, 32'h1001_0008, 2'b10, 1'b0, 1'b0, 32'h0080_0000, "lw_after_sb");
        load(0, 1, 32'h1001_000A, 2'b00, 1'b0, 1'b0, 32'hFFFF_FF80, "lb_neg");
        load(0, 1, 32'h1001_000A, 2'b00, 1'b1, 1'b0, 32'h0000_0080, "lbu");
        @(posedge clk); #1;
        chk("data_hold", dout[0], 32'h0000_0080);
        chk("hold_valid_low", 32'(vld[0]), 32'd0);
        store(0, 32'h1001_0008, 32'h0000_8001, 2'b01, 1'b0);
        load(0, 1, 32'h1001_0008, 2'b01, 1'b0, 1'b0, 32'hFFFF_8001, "lh_neg");
        load(0, 1, 32'h1001_0008, 2'b01, 1'b1, 1'b0, 32'h0000_8001, "lhu");
        store(0, 32'h1001_000B, 32'h0000_007F, 2'b00, 1'b0);
        load(0, 1, 32'h1001_000B, 2'b00, 1'b0, 1'b0, 32'h0000_007F, "lb_pos_lane3");
        load(0, 1, 32'h1001_000A, 2'b01, 1'b0, 1'b0, 32'h0000_7F80, "lh_upper_pos");
        load(0, 1, 32'h1001_0008, 2'b10, 1'b0, 1'b0, 32'h7F80_8001, "lw_merged");
        store(0, 32'h1001_000A, 32'h0000_F00F, 2'b01, 1'b0);
        load(0, 1, 32'h1001_000A, 2'b01, 1'b0, 1'b0, 32'hFFFF_F00F, "lh_upper_neg");
        load(0, 1, 32'h1001_0008, 2'b10, 1'b0, 1'b0, 32'hF00F_8001, "lw_sh_upper");

        // Latency 1: error conditions
        store(0, 32'h1001_0000, 32'h1122_3344, 2'b10, 1'b0);
        store(0, 32'h1001_0001, 32'h0000_AAAA, 2'b01, 1'b1);
        load(0, 1, 32'h1001_0000, 2'b10, 1'b0, 1'b0, 32'h1122_3344, "lw_after_bad_sh");
        store(0, 32'h1001_0000, 32'hFFFF_FFFF, 2'b11, 1'b1);
        exp_q.push_back({2'd0, 1'b0, 1'b1, 32'h0});
        issue(0, 1'b1, 1'b1, 32'h1001_0000, 32'hFFFF_FFFF, 2'b10, 1'b0);
        store(0, 32'h1001_0400, 32'hFFFF_FFFF, 2'b10, 1'b1);
        load(0, 1, 32'h1001_0000, 2'b10, 1'b0, 1'b0, 32'h1122_3344, "lw_after_bad_writes");
        load(0, 1, 32'h1001_0400, 2'b10, 1'b0, 1'b1, 32'h0, "lw_index_256");
        load(0, 1, 32'h1000_FFFC, 2'b10, 1'b0, 1'b1, 32'h0, "lw_below_base");
        load(0, 1, 32'h1001_0003, 2'b01, 1'b0, 1'b1, 32'h0, "lh_odd");
        load(0, 1, 32'h1001_0002, 2'b10, 1'b0, 1'b1, 32'h0, "lw_misaligned");
        load(0, 1, 32'h1001_0000, 2'b11, 1'b0, 1'b1, 32'h0, "read_size3");
        store(0, 32'h1001_03FC, 32'h55AA_55AA, 2'b10, 1'b0);
        load(0, 1, 32'h1001_03FC, 2'b10, 1'b0, 1'b0, 32'h55AA_55AA, "lw_last_word");

        // Latency 3: busy window, ignored write, back-to-back read
        store(1, 32'h1001_0010, 32'hCAFE_F00D, 2'b10, 1'b0);
        exp_q.push_back({2'd1, 1'b1, 1'b0, 32'hCAFE_F00D});
        issue(1, 1'b1, 1'b0, 32'h1001_0010, 32'h0, 2'b10, 1'b0);
        addr[1] = 32'h1001_0010; wdat[1] = 32'hBAD0_BAD0; sz[1] = 2'b10; mwr[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("rl3_busy", 32'(bsy[1]), 32'd1);
            chk("rl3_valid_low", 32'(vld[1]), 32'd0);
            if (i == 2) mwr[1] = 1'b0;
            @(posedge clk); #1;
        end
        chk("rl3_valid", 32'(vld[1]), 32'd1);
        load(1, 3, 32'h1001_0010, 2'b10, 1'b0, 1'b0, 32'hCAFE_F00D, "rl3_back_to_back");

        // Latency 4: reset in the middle of a read
        store(2, 32'h1001_0020, 32'h1234_5678, 2'b10, 1'b0);
        load(2, 4, 32'h1001_0020, 2'b10, 1'b0, 1'b0, 32'h1234_5678, "rl4_lw");
        store(2, 32'h1001_0024, 32'hA5A5_A5A5, 2'b10, 1'b0);
        issue(2, 1'b1, 1'b0, 32'h1001_0024, 32'h0, 2'b10, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst[2] = 1'b1;
        #1;
        chk("midrst_data", dout[2], 32'h0);
        chk("midrst_valid", 32'(vld[2]), 32'd0);
        chk("midrst_busy", 32'(bsy[2]), 32'd0);
        chk("midrst_error", 32'(err[2]), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst[2] = 1'b0;
        n_valid = 0;
        repeat (8) begin
            @(negedge clk);
            if (vld[2] === 1'b1) n_valid++;
        end
        chk("midrst_no_response", 32'(n_valid), 32'd0);
        @(posedge clk); #1;
        load(2, 4, 32'h1001_0020, 2'b10, 1'b0, 1'b0, 32'h1234_5678, "rl4_retained");

        repeat (5) @(posedge clk);
        chk("pending_responses", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
